// File: rtl/mem_interface_if.sv
// mem_interface_if: request/response bus between the control unit and the memory unit.
interface mem_interface_if #(parameter int DATA_WIDTH = 32);
   logic                  mem_read;
   logic                  mem_write;
   logic [DATA_WIDTH-1:0] mar_data;
   logic [DATA_WIDTH-1:0] mdr_data;
   logic [DATA_WIDTH-1:0] m_data_out;
   logic                  mem_ready;
   logic                  busy;
   logic                  addr_err;
   logic                  req_err;
   modport master (
      output mem_read, mem_write, mar_data, mdr_data,
      input  m_data_out, mem_ready, busy, addr_err, req_err
   );
   modport slave (
      input  mem_read, mem_write, mar_data, mdr_data,
      output m_data_out, mem_ready, busy, addr_err, req_err
   );
endinterface

// File: rtl/mem_interface.sv
// mem_interface: word-addressed memory with programmable wait states and a one-cycle ready pulse.
module mem_interface #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_BITS   = 9,
   parameter int WAIT_STATES = 2
) (
   input logic clk,
   input logic reset,
   mem_interface_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   localparam logic [3:0] WS = 4'(WAIT_STATES);
   state_t                state, state_nx;
   logic [3:0]            wcnt;
   logic [DATA_WIDTH-1:0] addr, data;
   logic                  rd, wr;
   logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];
   logic                  req, go, oor, ok;
   assign req = bus.mem_read | bus.mem_write;
   assign go  = (state == ACCESS) && (wcnt == 4'd0);
   assign oor = addr[DATA_WIDTH-1:ADDR_BITS] != '0;
   assign ok  = go && !oor && !(rd && wr);
   always_comb begin
      state_nx = state;
      state_nx = (state == IDLE) ? (req ? ACCESS : IDLE) :
                 (state == ACCESS) ? (go ? DONE : ACCESS) : IDLE;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         wcnt           <= 4'd0;
         addr           <= '0;
         data           <= '0;
         rd             <= 1'b0;
         wr             <= 1'b0;
         bus.m_data_out <= '0;
         bus.mem_ready  <= 1'b0;
         bus.busy       <= 1'b0;
         bus.addr_err   <= 1'b0;
         bus.req_err    <= 1'b0;
      end else begin
         state         <= state_nx;
         bus.mem_ready <= go;
         bus.busy      <= state_nx != IDLE;
         if (state == IDLE && req) begin
            addr <= bus.mar_data;
            data <= bus.mdr_data;
            rd   <= bus.mem_read;
            wr   <= bus.mem_write;
            wcnt <= WS;
         end else if (state == ACCESS && wcnt != 4'd0) begin
            wcnt <= wcnt - 4'd1;
         end
         if (go && oor) bus.addr_err <= 1'b1;
         if (go && rd && wr) bus.req_err <= 1'b1;
         if (ok && rd) bus.m_data_out <= mem[addr[ADDR_BITS-1:0]];
      end
   end
   // Storage is deliberately outside the reset domain; reset forces IDLE so no access can fire.
   always_ff @(posedge clk) begin
      if (ok && wr) mem[addr[ADDR_BITS-1:0]] <= data;
   end
endmodule

// File: tb/tb_mem_interface.sv
// tb_mem_interface: scoreboard bench driving a WAIT_STATES=2 and a WAIT_STATES=0 instance in parallel.
module tb_mem_interface;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        mem_read = 1'b0, mem_write = 1'b0;
   logic [31:0] mar_data = '0, mdr_data = '0;
   int          checks = 0, failures = 0;
   logic [31:0] sb [$];
   logic [31:0] model [int];
   mem_interface_if #(.DATA_WIDTH(32)) bus_a ();
   mem_interface_if #(.DATA_WIDTH(32)) bus_b ();
   assign bus_a.mem_read  = mem_read;
   assign bus_a.mem_write = mem_write;
   assign bus_a.mar_data  = mar_data;
   assign bus_a.mdr_data  = mdr_data;
   assign bus_b.mem_read  = mem_read;
   assign bus_b.mem_write = mem_write;
   assign bus_b.mar_data  = mar_data;
   assign bus_b.mdr_data  = mdr_data;
   mem_interface #(.DATA_WIDTH(32), .ADDR_BITS(9), .WAIT_STATES(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   mem_interface #(.DATA_WIDTH(32), .ADDR_BITS(9), .WAIT_STATES(0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
   always #5 clk = ~clk;

   task automatic req(input bit b, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] alt, output int lat, output logic [31:0] q, output logic bz,
                      output logic rdy_after);
      @(negedge clk);
      mem_read = rd; mem_write = wr; mar_data = a; mdr_data = d;
      @(posedge clk); #1;
      bz = b ? bus_b.busy : bus_a.busy;
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0; mar_data = alt; mdr_data = ~d;
      lat = -1; q = 'x; rdy_after = 1'bx;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (b ? bus_b.mem_ready : bus_a.mem_ready) begin
            lat = i;
            q = b ? bus_b.m_data_out : bus_a.m_data_out;
            break;
         end
      end
      if (lat > 0) begin
         @(posedge clk); #1;
         rdy_after = b ? bus_b.mem_ready : bus_a.mem_ready;
      end
   endtask

   task automatic test_reset;
      #2 reset = 1'b1;
      #1;
      checks++; if (bus_a.m_data_out !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus_a.m_data_out); end
      checks++; if ({bus_a.mem_ready, bus_a.busy, bus_a.addr_err, bus_a.req_err} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {bus_a.mem_ready, bus_a.busy, bus_a.addr_err, bus_a.req_err}); end
      checks++; if ({bus_b.mem_ready, bus_b.busy, bus_b.m_data_out} !== 34'b0) begin failures++; $display("FAIL reset_b got=%h exp=0", {bus_b.mem_ready, bus_b.busy, bus_b.m_data_out}); end
      @(posedge clk); @(negedge clk); reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++; if (bus_a.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", bus_a.busy); end
      end
   endtask

   task automatic test_round_trip;
      int lat; logic [31:0] q; logic bz, ra;
      req(0, 0, 1, 32'h10, 32'hDEADBEEF, 32'h0, lat, q, bz, ra);
      model[32'h10] = 32'hDEADBEEF;
      checks++; if (lat !== 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", lat); end
      checks++; if (bz !== 1'b1) begin failures++; $display("FAIL wr_busy got=%b exp=1", bz); end
      checks++; if (ra !== 1'b0) begin failures++; $display("FAIL ready_width got=%b exp=0", ra); end
      sb.push_back(model[32'h10]);
      req(0, 1, 0, 32'h10, 32'h0, 32'h0, lat, q, bz, ra);
      checks++; if (lat !== 3) begin failures++; $display("FAIL rd_latency got=%0d exp=3", lat); end
      checks++; if (q !== sb[0]) begin failures++; $display("FAIL rd_data got=%h exp=%h", q, sb[0]); end
      void'(sb.pop_front());
   endtask

   task automatic test_capture_isolation;
      int lat; logic [31:0] q; logic bz, ra;
      req(0, 0, 1, 32'h20, 32'h11111111, 32'h0, lat, q, bz, ra);
      model[32'h20] = 32'h11111111;
      sb.push_back(model[32'h10]);
      req(0, 1, 0, 32'h10, 32'h0, 32'h20, lat, q, bz, ra);
      checks++; if (q !== sb[0]) begin failures++; $display("FAIL isolation got=%h exp=%h", q, sb[0]); end
      void'(sb.pop_front());
      sb.push_back(model[32'h20]);
      req(0, 1, 0, 32'h20, 32'h0, 32'h10, lat, q, bz, ra);
      checks++; if (q !== sb[0]) begin failures++; $display("FAIL rd_0x20 got=%h exp=%h", q, sb[0]); end
      void'(sb.pop_front());
   endtask

   task automatic test_out_of_range;
      int lat; logic [31:0] q; logic bz, ra;
      req(0, 0, 1, 32'h0, 32'hCAFE0000, 32'h0, lat, q, bz, ra);
      model[32'h0] = 32'hCAFE0000;
      checks++; if (bus_a.addr_err !== 1'b0) begin failures++; $display("FAIL addr_err_early got=%b exp=0", bus_a.addr_err); end
      req(0, 0, 1, 32'h200, 32'h12345678, 32'h0, lat, q, bz, ra);
      checks++; if (lat !== 3) begin failures++; $display("FAIL oor_latency got=%0d exp=3", lat); end
      checks++; if (bus_a.addr_err !== 1'b1) begin failures++; $display("FAIL addr_err got=%b exp=1", bus_a.addr_err); end
      sb.push_back(model[32'h0]);
      req(0, 1, 0, 32'h0, 32'h0, 32'h0, lat, q, bz, ra);
      checks++; if (q !== sb[0]) begin failures++; $display("FAIL oor_nowrite got=%h exp=%h", q, sb[0]); end
      void'(sb.pop_front());
      checks++; if (bus_a.addr_err !== 1'b1) begin failures++; $display("FAIL addr_err_sticky got=%b exp=1", bus_a.addr_err); end
   endtask

   task automatic test_conflict;
      int lat; logic [31:0] q; logic bz, ra;
      req(0, 0, 1, 32'h5, 32'h55AA55AA, 32'h0, lat, q, bz, ra);
      model[32'h5] = 32'h55AA55AA;
      sb.push_back(model[32'h5]);
      req(0, 1, 0, 32'h5, 32'h0, 32'h0, lat, q, bz, ra);
      checks++; if (q !== sb[0]) begin failures++; $display("FAIL rd_0x5 got=%h exp=%h", q, sb[0]); end
      void'(sb.pop_front());
      checks++; if (bus_a.req_err !== 1'b0) begin failures++; $display("FAIL req_err_early got=%b exp=0", bus_a.req_err); end
      req(0, 1, 1, 32'h5, 32'hFFFFFFFF, 32'h0, lat, q, bz, ra);
      checks++; if (lat !== 3) begin failures++; $display("FAIL conflict_latency got=%0d exp=3", lat); end
      checks++; if (bus_a.req_err !== 1'b1) begin failures++; $display("FAIL req_err got=%b exp=1", bus_a.req_err); end
      checks++; if (q !== 32'h55AA55AA) begin failures++; $display("FAIL conflict_hold got=%h exp=55aa55aa", q); end
      sb.push_back(model[32'h5]);
      req(0, 1, 0, 32'h5, 32'h0, 32'h0, lat, q, bz, ra);
      checks++; if (q !== sb[0]) begin failures++; $display("FAIL conflict_nowrite got=%h exp=%h", q, sb[0]); end
      void'(sb.pop_front());
   endtask

   task automatic test_reset_write;
      int lat; logic [31:0] q; logic bz, ra;
      req(0, 0, 1, 32'h3, 32'h0BADF00D, 32'h0, lat, q, bz, ra);
      model[32'h3] = 32'h0BADF00D;
      @(negedge clk);
      mem_write = 1'b1; mar_data = 32'h3; mdr_data = 32'hA5A5A5A5;
      @(posedge clk); #1;
      mem_write = 1'b0;
      #3 reset = 1'b1;
      #1;
      checks++; if (bus_a.m_data_out !== 32'h0) begin failures++; $display("FAIL midrst_data got=%h exp=0", bus_a.m_data_out); end
      checks++; if ({bus_a.busy, bus_a.addr_err, bus_a.req_err} !== 3'b0) begin failures++; $display("FAIL midrst_flags got=%b exp=000", {bus_a.busy, bus_a.addr_err, bus_a.req_err}); end
      checks++; if (bus_b.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy_b got=%b exp=0", bus_b.busy); end
      @(posedge clk); @(negedge clk); reset = 1'b0;
      sb.push_back(model[32'h3]);
      req(0, 1, 0, 32'h3, 32'h0, 32'h0, lat, q, bz, ra);
      checks++; if (q !== sb[0]) begin failures++; $display("FAIL rst_nocommit got=%h exp=%h", q, sb[0]); end
      void'(sb.pop_front());
      sb.push_back(model[32'h3]);
      req(1, 1, 0, 32'h3, 32'h0, 32'h0, lat, q, bz, ra);
      checks++; if (lat !== 1) begin failures++; $display("FAIL w0_rd_latency got=%0d exp=1", lat); end
      checks++; if (q !== sb[0]) begin failures++; $display("FAIL w0_nocommit got=%h exp=%h", q, sb[0]); end
      void'(sb.pop_front());
   endtask

   task automatic test_wait0;
      int lat; logic [31:0] q; logic bz, ra;
      for (int i = 0; i < 3; i++) begin
         logic [31:0] a, d;
         a = 32'h40 + 32'(i);
         d = $urandom;
         req(1, 0, 1, a, d, 32'h0, lat, q, bz, ra);
         model[a] = d;
         checks++; if (lat !== 1) begin failures++; $display("FAIL w0_wr_latency got=%0d exp=1", lat); end
         checks++; if (ra !== 1'b0) begin failures++; $display("FAIL w0_ready_width got=%b exp=0", ra); end
         sb.push_back(model[a]);
         req(1, 1, 0, a, 32'h0, ~a, lat, q, bz, ra);
         checks++; if (q !== sb[0]) begin failures++; $display("FAIL w0_rd_data got=%h exp=%h", q, sb[0]); end
         void'(sb.pop_front());
      end
   endtask

   initial begin
      test_reset;
      test_round_trip;
      test_capture_isolation;
      test_out_of_range;
      test_conflict;
      test_reset_write;
      test_wait0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_interface.md
# mem_interface

Word-addressed synchronous memory unit with a wait-state handshake, sitting directly downstream of the datapath's MAR/MDR pair. It captures the MAR address and MDR data on a read or write strobe, performs the access after a programmable number of wait states, and returns read data on `m_data_out`, which drives the datapath's `m_data_in`. The control sequencer stalls on `mem_ready`. Out-of-range and conflicting requests complete the handshake but are flagged and have no effect on memory.

## Interface
- `DATA_WIDTH`, 32, word width; matches the datapath register size.
- `ADDR_BITS`, 9, number of implemented word-address bits (512 words).
- `WAIT_STATES`, 2, extra cycles between request capture and access; legal range 0–15.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `mem_read`  input  1  read request strobe from the control unit.
- `mem_write`  input  1  write request strobe from the control unit.
- `mar_data`  input  DATA_WIDTH  word address from MAR.
- `mdr_data`  input  DATA_WIDTH  write data from the MDR output.
- `m_data_out`  output  DATA_WIDTH  read data; drives the datapath `m_data_in`.
- `mem_ready`  output  1  single-cycle completion pulse.
- `busy`  output  1  high while a request is in flight (`ACCESS` or `DONE`).
- `addr_err`  output  1  sticky: out-of-range address seen.
- `req_err`  output  1  sticky: `mem_read` and `mem_write` sampled together.

## Operation
- The storage array holds `2**ADDR_BITS` words. Reset does not clear it; contents are undefined until written.
- State machine states: `IDLE`, `ACCESS`, `DONE`.
- **IDLE**
  - On an edge with `mem_read` or `mem_write` high: latch address, data and op into internal registers, load `wcnt = WAIT_STATES`, go to `ACCESS`.
  - The latched registers are the only source used afterwards; MAR/MDR may change freely once the request is captured.
- **ACCESS**
  - While `wcnt != 0`: decrement `wcnt` each edge.
  - On the edge where `wcnt == 0`, perform the access and go to `DONE`:
    - Read: `m_data_out` ← `mem[addr[ADDR_BITS-1:0]]`.
    - Write: `mem[addr]` ← data; `m_data_out` is unchanged.
- **DONE**
  - `mem_ready` = 1 for this one cycle.
  - Next edge returns to `IDLE` unconditionally.
- Strobes sampled in `ACCESS` or `DONE` are ignored; there is no queuing.
- Out-of-range address (`addr[DATA_WIDTH-1:ADDR_BITS] != 0`):
  - The access is suppressed: no write, and `m_data_out` is held.
  - `addr_err` is set on the access edge.
  - The full handshake still completes.
- Read and write sampled together in `IDLE`:
  - The request is captured, but the access is suppressed.
  - `req_err` is set on the access edge.
  - Handshake timing is unchanged.
- `addr_err` and `req_err` clear only on reset.

## Timing
- Reset values: state `IDLE`, `wcnt` = 0, `m_data_out` = 0, `mem_ready` = 0, `busy` = 0, `addr_err` = 0, `req_err` = 0.
- Let the request be sampled at edge E0:
  - Access occurs at edge E0+WAIT_STATES+1.
  - `mem_ready` is high from that edge until edge E0+WAIT_STATES+2.
- Read data is valid in the same cycle `mem_ready` is high. It stays stable until the next successful read completes.
- Minimum request-to-request spacing: WAIT_STATES+3 edges. The next request can be sampled at the edge that leaves `DONE` → `IDLE` plus one.
- `busy` goes high the cycle after E0 and low when leaving `DONE`.
- Reset mid-operation:
  - The FSM returns immediately to `IDLE` and all outputs take their reset values.
  - A write whose access edge has not yet occurred is not committed.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The strobe is level-sampled. A strobe still high when the FSM returns to `IDLE` starts a new request, so the controller must deassert the strobe on `mem_ready`.

## Test plan
- Reset then idle: assert `reset` mid-cycle → all outputs 0 asynchronously; `busy` stays 0 with no strobes.
- Write/read round trip (WAIT_STATES=2):
  - Write `mdr_data`=0xDEADBEEF to `mar_data`=0x00000010 → `mem_ready` pulses 3 edges after capture.
  - Then read 0x10 → `m_data_out`=0xDEADBEEF coincident with `mem_ready`.
- Capture isolation: change `mar_data` to 0x20 the cycle after a read of 0x10 is captured → data from 0x10 is returned.
- Out-of-range: write 0x12345678 to `mar_data`=0x00000200 → `mem_ready` pulses, `addr_err`=1, and a read of address 0x000 returns its prior value.
- Conflict: `mem_read` = `mem_write` = 1 at address 0x5 → `req_err`=1, memory at 0x5 unchanged, `m_data_out` unchanged.
- Reset during write: start a write of 0xA5A5A5A5 to 0x3 and assert `reset` in the first `ACCESS` cycle → outputs reset; a subsequent read of 0x3 returns the old value. Repeat with WAIT_STATES=0 → ready one edge after capture.
